// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART transmit arbiter.
// The master modport belongs to the arbiter, the slave modport to its environment.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic [ID_W-1:0]      grant_id;
    logic                 active;

    modport master (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_start, tx_data, grant_id, active
    );

    modport slave (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_start, tx_data, grant_id, active
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Define UART_ARB_ID_PREFIX_EN to precede every granted byte with a header byte {4'hA, id}.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int GAP_CYCLES = 16
) (
    input logic clk,
    input logic rst,
    uart_tx_arbiter_if.master bus
);

    typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, GAP, HDR} state_t;

    localparam logic [7:0] GAP_INIT = 8'(GAP_CYCLES);

    state_t          state, state_nx;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_id_q;
    logic [ID_W-1:0] win, hi_idx, lo_idx;
    logic            hi_found, lo_found, any_req;
    logic [7:0]      win_byte;
    logic [7:0]      tx_q;
    logic [7:0]      gap_cnt;
    logic            grant, gap_load;
`ifdef UART_ARB_ID_PREFIX_EN
    logic [7:0]      data_q;
    logic            hdr_phase;
    logic            hdr_done;
`endif

    // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        win_byte = 8'h00;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (bus.req_valid[j]) begin
                if (!hi_found && (ID_W'(j) >= rr_ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(j);
                end
                if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = ID_W'(j);
                end
            end
        end
        any_req = lo_found;
        win     = hi_found ? hi_idx : lo_idx;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (ID_W'(j) == win) begin
                win_byte = bus.req_data[8*j +: 8];
            end
        end
    end

    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        gap_load = 1'b0;
`ifdef UART_ARB_ID_PREFIX_EN
        hdr_done = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (any_req && !bus.tx_busy) begin
                    grant = 1'b1;
`ifdef UART_ARB_ID_PREFIX_EN
                    state_nx = HDR;
`else
                    state_nx = START;
`endif
                end
            end
`ifdef UART_ARB_ID_PREFIX_EN
            HDR:     state_nx = WAIT_HI;
`endif
            START:   state_nx = WAIT_HI;
            WAIT_HI: if (bus.tx_busy) state_nx = WAIT_LO;
            WAIT_LO: begin
                if (!bus.tx_busy) begin
`ifdef UART_ARB_ID_PREFIX_EN
                    // Header frame done: data byte follows with no idle gap.
                    if (hdr_phase) begin
                        hdr_done = 1'b1;
                        state_nx = START;
                    end else
`endif
                    if (GAP_CYCLES == 0) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = GAP;
                        gap_load = 1'b1;
                    end
                end
            end
            GAP:     if (gap_cnt <= 8'd1) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            grant_id_q <= '0;
            tx_q       <= 8'h00;
            gap_cnt    <= 8'h00;
`ifdef UART_ARB_ID_PREFIX_EN
            data_q     <= 8'h00;
            hdr_phase  <= 1'b0;
`endif
        end else begin
            if (grant) begin
                grant_id_q <= win;
                rr_ptr     <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
`ifdef UART_ARB_ID_PREFIX_EN
                tx_q       <= {4'hA, 4'(win)};
                data_q     <= win_byte;
                hdr_phase  <= 1'b1;
`else
                tx_q       <= win_byte;
`endif
            end
`ifdef UART_ARB_ID_PREFIX_EN
            if (hdr_done) begin
                tx_q      <= data_q;
                hdr_phase <= 1'b0;
            end
`endif
            if (gap_load) begin
                gap_cnt <= GAP_INIT;
            end else if (state == GAP && gap_cnt != 8'h00) begin
                gap_cnt <= gap_cnt - 8'h01;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            bus.req_ready[j] = (state == START) && (grant_id_q == ID_W'(j));
        end
`ifdef UART_ARB_ID_PREFIX_EN
        bus.tx_start = (state == START) || (state == HDR);
`else
        bus.tx_start = (state == START);
`endif
    end

    assign bus.tx_data  = tx_q;
    assign bus.grant_id = grant_id_q;
    assign bus.active   = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a busy-flag transmitter model, a grant scoreboard
// checked on every tx_start, a table of request masks and hand-written corner cases.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int ID_W     = 2;
    localparam int GAP      = 16;
    localparam int BUSY_LEN = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .ID_W      (ID_W),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] ready;
        logic [1:0] id;
    } exp_t;

    typedef struct {
        logic [3:0] mask;
        int         n;
        logic [7:0] ids;   // grant order, two bits per grant, first grant in [1:0]
    } vec_t;

    exp_t       sb_q[$];
    vec_t       tbl[7];
    logic [7:0] bytes[4];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         fall_cyc = 0;
    int         busy_cnt = 0;
    bit         sticky, busy_force, saw_start, started;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive_bytes();
        bus.req_data = {bytes[3], bytes[2], bytes[1], bytes[0]};
    endtask

    task automatic expect_grant(input logic [1:0] id);
        exp_t e;
`ifdef UART_ARB_ID_PREFIX_EN
        e.data  = {4'hA, 2'b00, id};
        e.ready = 4'b0000;
        e.id    = id;
        sb_q.push_back(e);
`endif
        e.data  = bytes[id];
        e.ready = 4'b0001 << id;
        e.id    = id;
        sb_q.push_back(e);
    endtask

    // One clock: sample outputs on the falling edge, score starts, model the transmitter.
    task automatic step();
        exp_t e;
        logic nb;
        @(negedge clk);
        cyc++;
        saw_start = bus.tx_start;
        if (bus.tx_start) begin
            check("active_at_start", 32'(bus.active), 32'd1);
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_start: got tx_data 0x%0h id %0d, required no start", bus.tx_data, bus.grant_id);
            end else begin
                e = sb_q.pop_front();
                check("tx_data", 32'(bus.tx_data), 32'(e.data));
                check("req_ready", 32'(bus.req_ready), 32'(e.ready));
                check("grant_id", 32'(bus.grant_id), 32'(e.id));
            end
            busy_cnt = BUSY_LEN;
        end else begin
            check("ready_idle", 32'(bus.req_ready), 32'd0);
            if (busy_cnt > 0) busy_cnt--;
        end
        nb = (busy_cnt > 0) || busy_force;
        if (bus.tx_busy && !nb) fall_cyc = cyc;
        bus.tx_busy = nb;
        if (!sticky) bus.req_valid = bus.req_valid & ~bus.req_ready;
    endtask

    task automatic wait_start(input int budget, input string name);
        int k = 0;
        do begin
            step();
            k++;
        end while (!saw_start && k < budget);
        check(name, 32'(saw_start), 32'd1);
    endtask

    task automatic grant_rest();
`ifdef UART_ARB_ID_PREFIX_EN
        wait_start(40, "data_start");
`endif
    endtask

    task automatic wait_drain(input int budget, input string name);
        int  k = 0;
        bit  done = 1'b0;
        while (!done && k < budget) begin
            step();
            k++;
            done = (bus.req_valid == '0) && !bus.active;
        end
        check(name, 32'(done), 32'd1);
        check({name, "_queue"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        sticky         = 1'b1;
        busy_force     = 1'b0;
        bus.tx_busy    = 1'b0;
        bus.req_valid  = 4'hF;
        bytes          = '{8'h10, 8'h11, 8'h12, 8'h13};
        drive_bytes();

        // Grant orders follow from rr_ptr carried over from the previous record.
        tbl[0] = '{mask: 4'b0100, n: 1, ids: {2'd0, 2'd0, 2'd0, 2'd2}};
        tbl[1] = '{mask: 4'b0011, n: 2, ids: {2'd0, 2'd0, 2'd1, 2'd0}};
        tbl[2] = '{mask: 4'b1001, n: 2, ids: {2'd0, 2'd0, 2'd0, 2'd3}};
        tbl[3] = '{mask: 4'b1111, n: 4, ids: {2'd0, 2'd3, 2'd2, 2'd1}};
        tbl[4] = '{mask: 4'b0001, n: 1, ids: {2'd0, 2'd0, 2'd0, 2'd0}};
        tbl[5] = '{mask: 4'b1010, n: 2, ids: {2'd0, 2'd0, 2'd3, 2'd1}};
        tbl[6] = '{mask: 4'b0110, n: 2, ids: {2'd0, 2'd0, 2'd2, 2'd1}};

        repeat (3) step();
        check("rst_tx_start", 32'(bus.tx_start), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'h00);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_grant_id", 32'(bus.grant_id), 32'd0);
        check("rst_active", 32'(bus.active), 32'd0);

        // Fairness: four continuous requesters rotate 0,1,2,3,0.
        rst = 1'b0;
        for (int i = 0; i < 5; i++) expect_grant(2'(i % 4));
        for (int f = 0; f < 5; f++) begin
            if (f == 0) begin
                step();
                check("first_latency", 32'(saw_start), 32'd1);
            end else begin
                wait_start(60, "fair_start");
                check("fair_spacing", 32'(cyc - fall_cyc), 32'(GAP + 2));
            end
            grant_rest();
            step();
            check("pulse_tx_start", 32'(bus.tx_start), 32'd0);
            check("pulse_req_ready", 32'(bus.req_ready), 32'd0);
        end
        sticky        = 1'b0;
        bus.req_valid = 4'h0;
        wait_drain(200, "fair_drain");

        bytes = '{8'hA0, 8'hB1, 8'h3C, 8'hD3};
        drive_bytes();
        for (int r = 0; r < 7; r++) begin
            bus.req_valid = tbl[r].mask;
            for (int k = 0; k < tbl[r].n; k++) expect_grant(tbl[r].ids[2*k +: 2]);
            step();
            check("tbl_latency", 32'(saw_start), 32'd1);
            wait_drain(600, "tbl_drain");
        end

        // Transmitter already busy while a request waits in IDLE.
        busy_force    = 1'b1;
        bus.tx_busy   = 1'b1;
        bus.req_valid = 4'b0001;
        expect_grant(2'd0);
        started = 1'b0;
        repeat (6) begin
            step();
            if (saw_start) started = 1'b1;
        end
        check("busy_hold", 32'(started), 32'd0);
        busy_force  = 1'b0;
        bus.tx_busy = (busy_cnt > 0);
        step();
        check("busy_release", 32'(saw_start), 32'd1);
        wait_drain(300, "busy_drain");

        // Reset during WAIT_LO; the remaining requests must restart from rr_ptr 0.
        bus.req_valid = 4'b1101;
        expect_grant(2'd2);
        step();
        check("mid_latency", 32'(saw_start), 32'd1);
        grant_rest();
        repeat (3) step();
        check("pre_reset_active", 32'(bus.active), 32'd1);
        rst = 1'b1;
        step();
        check("mid_rst_active", 32'(bus.active), 32'd0);
        check("mid_rst_tx_start", 32'(bus.tx_start), 32'd0);
        check("mid_rst_tx_data", 32'(bus.tx_data), 32'h00);
        check("mid_rst_grant_id", 32'(bus.grant_id), 32'd0);
        check("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        expect_grant(2'd0);
        expect_grant(2'd3);
        wait_drain(400, "rst_drain");

        // Requester 3 with 8'h55 (header 8'hA3 first when the prefix is enabled).
        bytes[3] = 8'h55;
        drive_bytes();
        bus.req_valid = 4'b1000;
        expect_grant(2'd3);
        step();
        check("id3_latency", 32'(saw_start), 32'd1);
        wait_drain(300, "id3_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

- Round-robin scheduler sharing one `uart_transmitter` serial datapath among up to 16 byte producers.
- Arbitrates pending byte requests and latches the winner's byte.
- Issues a one-cycle start strobe with the byte to the transmitter and tracks its busy flag until the frame completes.
- Enforces a programmable idle gap on the line before re-arbitrating.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `ID_W`, default 2: width of `grant_id`; must satisfy 2^ID_W >= NUM_REQ.
- `GAP_CYCLES`, default 16: idle clocks after each frame completes, 0..255.
- `clk`  in  1: sole clock; all logic rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NUM_REQ: bit i high means requester i has a byte pending. Held until `req_ready[i]`.
- `req_data`  in  8*NUM_REQ: byte of requester i on bits [8i+7:8i]. Stable while valid.
- `req_ready`  out  NUM_REQ: one-hot, one-cycle pulse; byte of requester i accepted.
- `tx_start`  out  1: one-cycle strobe to the transmitter.
- `tx_data`  out  8: byte for the transmitter; valid while `tx_start` is high and held until the next load.
- `tx_busy`  in  1: transmitter frame in progress.
- `grant_id`  out  ID_W: index of the current or last granted requester.
- `active`  out  1: high in every state except IDLE.

## Operation
- States: IDLE, START, WAIT_HI, WAIT_LO, GAP (plus HDR with the macro).
- IDLE: if any `req_valid` and `tx_busy`=0, grant g.
  - g is the first set bit searching upward from `rr_ptr`, wrapping modulo NUM_REQ.
  - At the edge: latch `req_data[g]` into the data register, set `grant_id`=g, `rr_ptr`=(g+1) mod NUM_REQ, go to START.
  - If `tx_busy`=1 or no valid bit is set, stay in IDLE.
- START: single cycle.
  - `tx_start`=1, `tx_data`=latched byte, `req_ready[g]`=1.
  - Go to WAIT_HI.
- WAIT_HI: wait for `tx_busy`=1, then go to WAIT_LO. `tx_busy` may already be high in the first WAIT_HI cycle.
- WAIT_LO: wait for `tx_busy`=0.
  - Then go to GAP, loading gap counter=GAP_CYCLES.
  - If GAP_CYCLES=0, go directly to IDLE.
- GAP: decrement counter each cycle; go to IDLE on the cycle the counter reaches 1.
- The rr pointer skips non-requesting indices.
  - A single continuous requester is served every frame.
  - Two or more continuous requesters alternate strictly.
- `req_valid` changes during START..GAP do not affect the current frame. They are sampled only in IDLE.
- `req_data` width arithmetic: fixed 8 bits per slot; no packing or truncation.
- Reset:
  - Every state forces IDLE, `rr_ptr`=0, counter=0.
  - Outputs on reset: `tx_start`=0, `tx_data`=8'h00, `req_ready`=0, `grant_id`=0, `active`=0.
  - An aborted frame is not retried. The transmitter's own state is outside this block's control.

## Timing
- Request to `tx_start`: 1 cycle. Valid seen in IDLE at cycle N; `tx_start` and `req_ready` are high in cycle N+1.
- `req_ready` and `tx_start` are coincident and both exactly one cycle wide.
- Back-to-back frame spacing: `tx_busy` falling edge to next `tx_start` is GAP_CYCLES+2 cycles minimum (GAP, then IDLE, then START).
- `active` rises in the START cycle and falls in the first IDLE cycle.
- Simultaneous requests in IDLE: exactly one grant per cycle; the others remain pending.

## Configuration
- `UART_ARB_ID_PREFIX_EN` defined:
  - START is preceded by HDR, which pulses `tx_start` with header byte {4'hA, g zero-extended to 4 bits}.
  - HDR is followed by WAIT_HI and WAIT_LO for the header frame, then START for the data byte. No gap between header and data.
  - `req_ready` pulses only in the data START cycle.
  - Request to first `tx_start` stays at 1 cycle.
- `UART_ARB_ID_PREFIX_EN` undefined: HDR is absent; one frame per grant exactly as described in Operation.

## Test plan
- Reset: hold `rst` 3 cycles with `req_valid`=4'hF → all outputs zero, `active`=0. After release, first grant is id 0.
- Single request: `req_valid`=4'b0100, data 8'h3C, transmitter busy for 10 cycles → `tx_start` one cycle later with `tx_data`=8'h3C, `req_ready`=4'b0100, `grant_id`=2. Next `tx_start` no earlier than 18 cycles after busy falls (GAP_CYCLES=16).
- Fairness: all four requesters continuously valid with bytes 8'h10/8'h11/8'h12/8'h13 → `tx_data` sequence 10,11,12,13,10 and one `req_ready` per frame.
- Busy at idle: `tx_busy` held high externally while `req_valid`=4'b0001 → no `tx_start` until busy drops. Start occurs 1 cycle after the IDLE cycle with busy low.
- Mid-frame reset: assert `rst` in WAIT_LO → next cycle IDLE, outputs zero, `rr_ptr`=0. A pending request is re-granted after release.
- Macro on: `req_valid`=4'b1000, data 8'h55 → `tx_data` 8'hA3 then 8'h55 across two busy frames; a single `req_ready` pulse, coincident with the 8'h55 start.
